tach_scan_sched: RTL and testbench
==================================

// Module: tach_scan_sched
// PURPOSE
//  Autonomous scanner/arbiter for the shared register bus (4-bit addr, read strobe, write enable) in front of the address decoder.
//  Every SCAN_DIV clocks it reads the tach counters of channels 0..2 and publishes atomic 16-bit snapshots.
//  Each channel read is a low-byte read with a countlread strobe, then the freezer wait, then a high-byte read.
//  The SPI slave has absolute priority; the scheduler owns the bus only while SPI is idle.
// PARAMETERS
//  SCAN_DIV  50000  clocks between scan starts (>= 64)
//  FRZ_WAIT  6      cycles between low-byte strobe and high-byte read (covers freezer + 8-bit latch)
//  GUARD     8      cycles SS must be synced-idle before the scheduler may take the bus
// PORTS
//  clk        in   1   system clock
//  reset      in   1   synchronous, active-high reset
//  enable     in   1   1 = periodic scanning on; 0 = divider held at 0, no new scans
//  ovr_clr    in   1   1-cycle pulse, clears overrun
//  ss         in   1   SPI slave select, active low, asynchronous to clk
//  spi_addr   in   4   SPI address
//  spi_rdt    in   1   SPI read strobe
//  spi_we     in   1   SPI write enable (post edge detector)
//  rddata     in   8   decoder read mux output
//  dec_addr   out  4   address to decoder
//  dec_rdt    out  1   read strobe to decoder
//  dec_we     out  1   write enable to decoder
//  tach0      out  16  channel 0 snapshot {high,low}
//  tach1      out  16  channel 1 snapshot
//  tach2      out  16  channel 2 snapshot
//  snap_valid out  1   1-cycle pulse; tach0..2 updated on this same edge
//  scan_busy  out  1   1 while the scheduler owns the bus
//  overrun    out  1   sticky: a scan tick arrived while a scan was still pending
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; divider=0; guard=0; ss sync flops=1 (idle); channel index=0.
//  ss goes through a 2-flop synchronizer (ss_s). guard counts up while ss_s=1, saturates at GUARD, clears to 0 when ss_s=0.
//  bus_ok = (guard==GUARD).
//  Bus mux: owner=SCHED when scan_busy=1, else SPI.
//   SPI owner: dec_* = spi_*.
//   SCHED owner: dec_we=0 always; dec_addr/dec_rdt come from the FSM.
//  Divider: counts while enable=1 and wraps at SCAN_DIV-1. The wrap cycle is tick. enable=0 holds it at 0.
//  pending is set by tick and cleared on entering RDL for channel 0.
//  If tick arrives while pending=1 or the FSM is not IDLE: overrun<=1 and the tick is dropped.
//  overrun clears only on ovr_clr or reset. If set and clear coincide, set wins.
//  FSM states: IDLE, RDL, WAIT, RDH, DONE.
//   IDLE: if pending && bus_ok, go to RDL with ch=0.
//   RDL (1 cyc): scan_busy=1, dec_addr=4*ch, dec_rdt=1; shadow low byte <= rddata. Next state WAIT, wcnt=0.
//   WAIT (FRZ_WAIT cyc): dec_addr=4*ch, dec_rdt=0.
//   RDH (1 cyc): dec_addr=4*ch+1; shadow high byte <= rddata. If ch==2, go to DONE; else ch+1 and go to RDL.
//   DONE (1 cyc): tach0..2 <= shadows, snap_valid=1, scan_busy=0. Next state IDLE.
//  scan_busy is registered: 1 in RDL/WAIT/RDH, else 0.
//  Scan latency from the first RDL cycle to the snap_valid cycle: 3*(FRZ_WAIT+2) cycles (24 at defaults).
//  Abort: ss_s=0 in any of RDL/WAIT/RDH causes the following:
//   - go to IDLE next edge with scan_busy=0
//   - pending is set again and all shadows are discarded
//   - tach0..2 are not updated and snap_valid is not pulsed
//   The scan restarts from channel 0 once bus_ok.
//  A tick dropped during an abort counts as an overrun.
//  Tach outputs only ever change in DONE, so all three words always come from one completed scan.
//  SPI reads of the tach high byte reflect the most recent low-byte strobe from either owner.
//  The host must read low then high within one SS frame.
//  reset mid-scan: FSM=IDLE, outputs return to reset values on that edge.
// TESTING
//  1 Reset, enable=1, SCAN_DIV=64, ss=1, rddata modelled from addr:
//    -> first snap_valid 24 cycles after RDL start.
//    -> tach0/1/2 equal the modelled {addr+1,addr} bytes.
//    -> dec_rdt pulses exactly at addr 0,4,8.
//  2 ss=0 held through a tick -> no scan; after ss=1 the first RDL comes GUARD+2 cycles later; no overrun for a single tick.
//  3 ss falls during channel 1 WAIT:
//    -> scan_busy=0 within 3 cycles; dec_*=spi_* afterwards.
//    -> tach0..2 unchanged, no snap_valid.
//    -> full rescan from ch0 after release.
//  4 ss=0 for > 2*SCAN_DIV -> overrun=1. ovr_clr pulse -> 0. ovr_clr coincident with a dropped tick -> stays 1.
//  5 spi_we=1 with spi_addr=4'h0 while scan_busy=1 -> dec_we stays 0. With ss idle and the scheduler idle -> dec_we follows spi_we.
//  6 Assert reset during RDH of ch2 -> next cycle all outputs 0 and FSM idle. Deassert -> normal scan on next tick.

Source files
------------

// File: rtl/tach_scan_sched.sv
// tach_scan_sched: periodic atomic tach snapshot scanner sharing the decoder bus with the SPI slave
module tach_scan_sched #(
    parameter int SCAN_DIV = 50000,
    parameter int FRZ_WAIT = 6,
    parameter int GUARD    = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        ovr_clr,
    input  logic        ss,
    input  logic [3:0]  spi_addr,
    input  logic        spi_rdt,
    input  logic        spi_we,
    input  logic [7:0]  rddata,
    output logic [3:0]  dec_addr,
    output logic        dec_rdt,
    output logic        dec_we,
    output logic [15:0] tach0,
    output logic [15:0] tach1,
    output logic [15:0] tach2,
    output logic        snap_valid,
    output logic        scan_busy,
    output logic        overrun
);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int GW = $clog2(GUARD + 1);
    localparam int WW = $clog2(FRZ_WAIT + 1);

    typedef enum logic [2:0] {IDLE, RDL, WAIT, RDH, DONE} state_t;

    state_t             state_q, state_d;
    logic [DW-1:0]      div_q, div_d;
    logic [GW-1:0]      guard_q, guard_d;
    logic [WW-1:0]      wcnt_q, wcnt_d;
    logic [1:0]         ch_q, ch_d;
    logic               ss_m_q, ss_s_q;
    logic               pending_q, pending_d;
    logic               overrun_q, overrun_d;
    logic               busy_q, busy_d;
    logic               snap_q, snap_d;
    logic [2:0][7:0]    lo_q, lo_d, hi_q, hi_d;
    logic [2:0][15:0]   t_q, t_d;
    logic               tick, accept, bus_ok, abort;

    assign tick   = enable && div_q == DW'(SCAN_DIV - 1);
    assign accept = tick && !pending_q && state_q == IDLE;
    assign bus_ok = guard_q == GW'(GUARD);
    assign abort  = !ss_s_q && (state_q == RDL || state_q == WAIT || state_q == RDH);

    // SPI owns the bus unless a scan is in flight; the scheduler never writes
    assign dec_we     = busy_q ? 1'b0 : spi_we;
    assign dec_rdt    = busy_q ? state_q == RDL : spi_rdt;
    assign dec_addr   = busy_q ? {ch_q, 1'b0, state_q == RDH} : spi_addr;
    assign tach0      = t_q[0];
    assign tach1      = t_q[1];
    assign tach2      = t_q[2];
    assign snap_valid = snap_q;
    assign scan_busy  = busy_q;
    assign overrun    = overrun_q;

    // divider, guard timer, overrun and scan FSM next-state
    always_comb begin
        div_d     = (!enable || tick) ? '0 : div_q + 1'b1;
        guard_d   = !ss_s_q ? '0 : bus_ok ? guard_q : guard_q + 1'b1;
        overrun_d = (tick && !accept) || (overrun_q && !ovr_clr);
        state_d   = state_q;
        ch_d      = ch_q;
        wcnt_d    = wcnt_q;
        pending_d = pending_q || accept;
        lo_d      = lo_q;
        hi_d      = hi_q;
        t_d       = t_q;
        snap_d    = 1'b0;
        if (abort) begin
            state_d   = IDLE;
            pending_d = 1'b1;
        end else begin
            case (state_q)
                IDLE: if (pending_q && bus_ok) begin
                    state_d   = RDL;
                    ch_d      = 2'd0;
                    pending_d = 1'b0;
                end
                RDL: begin
                    lo_d[ch_q] = rddata;
                    wcnt_d     = '0;
                    state_d    = WAIT;
                end
                WAIT: begin
                    wcnt_d  = wcnt_q + 1'b1;
                    state_d = wcnt_q == WW'(FRZ_WAIT - 1) ? RDH : WAIT;
                end
                RDH: begin
                    hi_d[ch_q] = rddata;
                    if (ch_q == 2'd2) begin
                        state_d = DONE;
                        snap_d  = 1'b1;
                        t_d     = {{rddata, lo_q[2]}, {hi_q[1], lo_q[1]}, {hi_q[0], lo_q[0]}};
                    end else begin
                        ch_d    = ch_q + 1'b1;
                        state_d = RDL;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        busy_d = state_d == RDL || state_d == WAIT || state_d == RDH;
    end

    // state registers, with the ss synchronizer resetting to idle-high
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            div_q     <= '0;
            guard_q   <= '0;
            wcnt_q    <= '0;
            ch_q      <= '0;
            ss_m_q    <= 1'b1;
            ss_s_q    <= 1'b1;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
            busy_q    <= 1'b0;
            snap_q    <= 1'b0;
            lo_q      <= '0;
            hi_q      <= '0;
            t_q       <= '0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            guard_q   <= guard_d;
            wcnt_q    <= wcnt_d;
            ch_q      <= ch_d;
            ss_m_q    <= ss;
            ss_s_q    <= ss_m_q;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            busy_q    <= busy_d;
            snap_q    <= snap_d;
            lo_q      <= lo_d;
            hi_q      <= hi_d;
            t_q       <= t_d;
        end
    end
endmodule

// File: tb/tb_tach_scan_sched.sv
// tb_tach_scan_sched: scoreboard bench for the tach scan scheduler
module tb_tach_scan_sched;
    localparam int SCAN_DIV = 64;
    localparam int FRZ_WAIT = 6;
    localparam int GUARD    = 8;

    logic        clk = 1'b0;
    logic        reset, enable, ovr_clr, ss, spi_rdt, spi_we;
    logic [3:0]  spi_addr;
    logic [7:0]  rddata, seed;
    logic [3:0]  dec_addr;
    logic        dec_rdt, dec_we, snap_valid, scan_busy, overrun;
    logic [15:0] tach0, tach1, tach2;

    int          errors = 0, checks = 0, cyc = 0, snap_cnt = 0, busy_start = 0, rd_cnt = 0, n;
    logic        busy_prev = 1'b0;
    logic [47:0] exp_q[$];
    logic [47:0] last_exp, e;

    tach_scan_sched #(.SCAN_DIV(SCAN_DIV), .FRZ_WAIT(FRZ_WAIT), .GUARD(GUARD)) dut (
        .clk(clk), .reset(reset), .enable(enable), .ovr_clr(ovr_clr), .ss(ss),
        .spi_addr(spi_addr), .spi_rdt(spi_rdt), .spi_we(spi_we), .rddata(rddata),
        .dec_addr(dec_addr), .dec_rdt(dec_rdt), .dec_we(dec_we),
        .tach0(tach0), .tach1(tach1), .tach2(tach2),
        .snap_valid(snap_valid), .scan_busy(scan_busy), .overrun(overrun)
    );

    // register file model: byte at address a is seed + 16*a
    assign rddata = seed + {dec_addr, 4'h0};

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] s);
        logic [47:0] v;
        for (int c = 0; c < 3; c++)
            v[16*c +: 16] = {s + 8'(64 * c + 16), s + 8'(64 * c)};
        exp_q.push_back(v);
        last_exp = v;
    endtask

    task automatic wait_busy(input int bound);
        int k = 0;
        while (!scan_busy && k < bound) begin
            step(1);
            k++;
        end
        if (!scan_busy) chk("busy_timeout", scan_busy, 1);
    endtask

    task automatic wait_snap(input int bound);
        int k = 0;
        int t = snap_cnt;
        while (snap_cnt == t && k < bound) begin
            step(1);
            k++;
        end
        if (snap_cnt == t) chk("snap_timeout", snap_cnt, t + 1);
    endtask

    // monitor: read strobe order, latency and snapshot contents against the scoreboard
    always @(negedge clk) begin
        if (scan_busy && !busy_prev) begin
            busy_start = cyc;
            rd_cnt = 0;
        end
        if (scan_busy && dec_rdt) begin
            chk("rdt_addr", dec_addr, 4 * rd_cnt);
            rd_cnt++;
        end
        if (snap_valid) begin
            if (exp_q.size() == 0) chk("snap_unexpected", snap_valid, 0);
            else begin
                e = exp_q.pop_front();
                chk("tach0", tach0, e[15:0]);
                chk("tach1", tach1, e[31:16]);
                chk("tach2", tach2, e[47:32]);
                chk("latency", cyc - busy_start, 3 * (FRZ_WAIT + 2));
                chk("rdt_count", rd_cnt, 3);
            end
            snap_cnt++;
        end
        busy_prev = scan_busy;
    end

    initial begin
        reset = 1; enable = 0; ovr_clr = 0; ss = 1;
        spi_addr = 0; spi_rdt = 0; spi_we = 0; seed = 8'h11;
        step(3);
        chk("rst_outs", {tach2, tach1, tach0, snap_valid, scan_busy, overrun, dec_we, dec_rdt, dec_addr}, 0);
        reset = 0;
        enable = 1;
        push(seed);
        wait_snap(200);

        enable = 0; ss = 0; seed = 8'h37;
        step(20);
        enable = 1;
        step(80);
        enable = 0;
        chk("t2_no_scan", scan_busy, 0);
        chk("t2_no_ovr", overrun, 0);
        chk("t2_snaps", snap_cnt, 1);
        push(seed);
        ss = 1;
        n = 0;
        while (!scan_busy && n < 40) begin
            step(1);
            n++;
        end
        chk("t2_guard_min", n >= GUARD + 2, 1);
        chk("t2_guard_max", n <= GUARD + 4, 1);
        wait_snap(100);

        seed = 8'h5C; enable = 1;
        wait_busy(100);
        step(10);
        chk("t3_ch1_wait", {dec_addr, dec_rdt}, {4'h4, 1'b0});
        ss = 0;
        n = 0;
        while (scan_busy && n < 10) begin
            step(1);
            n++;
        end
        chk("t3_abort_lat", n <= 3, 1);
        enable = 0;
        chk("t3_tach_hold", {tach2, tach1, tach0}, last_exp);
        spi_addr = 4'h7; spi_rdt = 1; spi_we = 1;
        #1;
        chk("t3_passthru", {dec_addr, dec_rdt, dec_we}, {4'h7, 1'b1, 1'b1});
        step(10);
        chk("t3_tach_hold2", {tach2, tach1, tach0}, last_exp);
        spi_addr = 0; spi_rdt = 0; spi_we = 0;
        seed = 8'hA3;
        push(seed);
        ss = 1;
        wait_snap(100);

        ss = 0; enable = 1;
        step(200);
        enable = 0;
        chk("t4_ovr_set", overrun, 1);
        ovr_clr = 1;
        step(1);
        ovr_clr = 0;
        chk("t4_ovr_clr", overrun, 0);
        enable = 1;
        step(63);
        ovr_clr = 1;
        step(1);
        ovr_clr = 0;
        enable = 0;
        chk("t4_ovr_coinc", overrun, 1);
        ovr_clr = 1;
        step(1);
        ovr_clr = 0;
        chk("t4_ovr_clr2", overrun, 0);
        seed = 8'h0F;
        push(seed);
        ss = 1;
        wait_snap(100);

        seed = 8'hC8; enable = 1;
        push(seed);
        wait_busy(100);
        spi_addr = 0; spi_we = 1;
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("t5_we_blocked", dec_we, 0);
        end
        wait_snap(100);
        enable = 0;
        step(2);
        chk("t5_we_pass", dec_we, 1);
        spi_we = 0;
        #1;
        chk("t5_we_low", dec_we, 0);

        seed = 8'h99; enable = 1;
        wait_busy(100);
        step(23);
        chk("t6_rdh_ch2", {dec_addr, dec_rdt}, {4'h9, 1'b0});
        reset = 1;
        step(1);
        chk("t6_rst_outs", {tach2, tach1, tach0, snap_valid, scan_busy, overrun, dec_we, dec_rdt, dec_addr}, 0);
        reset = 0;
        seed = 8'h42;
        push(seed);
        wait_snap(150);
        enable = 0;
        step(5);
        chk("end_queue", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
